wrapper_ibex_pmp_fsm: RTL and testbench

- Ibex-style PMP access-control wrapper inserted on a TL-UL link between a bus host and a device.
- Each host A-channel request is checked against 4 programmable regions. Allowed requests are forwarded to the device; denied requests are answered locally with an error, and an interrupt is raised until software acknowledges it.
- Regions are configured through a second TL-UL slave port, the CSR bank at 0xFFFF_FF00.

---
 rtl/wrapper_ibex_pmp_fsm_pkg.sv | 65 ++++++
 rtl/wrapper_ibex_pmp_fsm_pmp_region_check.sv | 67 ++++++
 rtl/wrapper_ibex_pmp_fsm.sv | 168 ++++++++++++++++
 tb/tb_wrapper_ibex_pmp_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wrapper_ibex_pmp_fsm_pkg.sv
// pmp_wrap_pkg: TL-UL channel types, FSM states, CSR offsets and pmpcfg field
// definitions shared by the PMP wrapper. Rev 1.0
`default_nettype none

package pmp_wrap_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_ACK         = 3'd0;
   localparam logic [2:0] OP_ACK_DATA    = 3'd1;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CHECK    = 3'd1;
   localparam logic [2:0] ST_FWD      = 3'd2;
   localparam logic [2:0] ST_DENY_RSP = 3'd3;
   localparam logic [2:0] ST_HALT     = 3'd4;

   // CSR word indices (address bits [4:2])
   localparam logic [2:0] CSR_IDX_CFG       = 3'd0;
   localparam logic [2:0] CSR_IDX_ADDR0     = 3'd1;
   localparam logic [2:0] CSR_IDX_DENY_ADDR = 3'd5;
   localparam logic [2:0] CSR_IDX_DENY_OP   = 3'd6;

   localparam int CFG_R    = 0;
   localparam int CFG_W    = 1;
   localparam int CFG_A_LO = 3;
   localparam int CFG_L    = 7;

   localparam logic [1:0] A_OFF   = 2'd0;
   localparam logic [1:0] A_TOR   = 2'd1;
   localparam logic [1:0] A_NA4   = 2'd2;
   localparam logic [1:0] A_NAPOT = 2'd3;

   function automatic logic is_write_op(input logic [2:0] op);
      return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/wrapper_ibex_pmp_fsm_pmp_region_check.sv
// pmp_region_check: combinational PMP matcher, lowest matching region decides.
// NAPOT matching is built only when PMP_NAPOT_EN is defined. Rev 1.0
`default_nettype none

module pmp_region_check
   import pmp_wrap_pkg::*;
#(
   parameter int PMP_REGIONS = 4
) (
   input  logic [8*PMP_REGIONS-1:0]     cfg_i,
   input  logic [PMP_REGIONS-1:0][31:0] addrs_i,
   input  logic [31:0]                  addr_i,
   input  logic [2:0]                   opcode_i,
   output logic                         allow_o
);

   logic [PMP_REGIONS-1:0] match;
   logic [PMP_REGIONS-1:0] perm_ok;
   logic                   unused_cfg;

   assign unused_cfg = ^cfg_i;

   for (genvar i = 0; i < PMP_REGIONS; i++) begin : g_region
      logic [1:0]  mode;
      logic [31:0] lo;
      logic        hit_tor;
      logic        hit_na4;
      logic        hit_napot;

      assign mode = cfg_i[8*i+CFG_A_LO +: 2];

      if (i == 0) begin : g_first
         assign lo = '0;
      end else begin : g_rest
         assign lo = addrs_i[i-1];
      end

      assign hit_tor = (addr_i >= lo) && (addr_i < addrs_i[i]);
      // modular difference keeps the 4-byte window correct at the top of memory
      assign hit_na4 = (addr_i - addrs_i[i]) < 32'd4;

`ifdef PMP_NAPOT_EN
      logic [31:0] napot_mask;
      assign napot_mask = ((addrs_i[i] ^ (addrs_i[i] + 32'd1)) << 2) | 32'd3;
      assign hit_napot  = (addr_i & ~napot_mask) == (addrs_i[i] & ~napot_mask);
`else
      assign hit_napot = 1'b0;
`endif

      assign match[i] = ((mode == A_TOR)   && hit_tor) ||
                        ((mode == A_NA4)   && hit_na4) ||
                        ((mode == A_NAPOT) && hit_napot);

      assign perm_ok[i] = ((opcode_i == OP_GET) && cfg_i[8*i+CFG_R]) ||
                          (is_write_op(opcode_i) && cfg_i[8*i+CFG_W]);
   end

   always_comb begin
      allow_o = 1'b0;
      for (int i = PMP_REGIONS - 1; i >= 0; i--) begin
         if (match[i]) allow_o = perm_ok[i];
      end
   end

endmodule

`default_nettype wire

// File: rtl/wrapper_ibex_pmp_fsm.sv
// wrapper_ibex_pmp_fsm: TL-UL PMP filter between host and device with a CSR port.
// Optional NAPOT mode via PMP_NAPOT_EN (see pmp_region_check). Rev 1.0
`default_nettype none

module wrapper_ibex_pmp_fsm
   import pmp_wrap_pkg::*;
#(
   parameter logic [31:0] CSR_BASE    = 32'hFFFF_FF00,
   parameter int          PMP_REGIONS = 4
) (
   input  logic     clk,
   input  logic     rst,
   output logic     irq_q,
   input  tl_h2d_t  tl_h2pmp,
   output tl_d2h_t  tl_pmp2h,
   output tl_h2d_t  tl_pmp2d,
   input  tl_d2h_t  tl_d2pmp,
   input  tl_h2d_t  tl_cpu2csr,
   output tl_d2h_t  tl_csr2cpu
);

   logic [2:0]                   state_q, state_d;
   tl_h2d_t                      req_q;
   logic [8*PMP_REGIONS-1:0]     cfg_q;
   logic [PMP_REGIONS-1:0][31:0] pmpaddr_q;
   logic [31:0]                  deny_addr_q;
   logic [2:0]                   deny_op_q;

   logic        csr_valid_q, csr_err_q;
   logic [2:0]  csr_op_q;
   logic [1:0]  csr_size_q;
   logic [7:0]  csr_src_q;
   logic [31:0] csr_data_q;

   logic        allow;
   logic        csr_req, csr_hit, csr_get, csr_put, csr_we, go_idle;
   logic [2:0]  csr_idx;
   logic [3:0]  csr_wmask;
   logic [31:0] csr_rdata;
   logic        unused_bits;

   assign unused_bits = ^{tl_cpu2csr.a_param, tl_cpu2csr.a_address[1:0]};

   pmp_region_check #(.PMP_REGIONS(PMP_REGIONS)) u_check (
      .cfg_i    (cfg_q),
      .addrs_i  (pmpaddr_q),
      .addr_i   (req_q.a_address),
      .opcode_i (req_q.a_opcode),
      .allow_o  (allow)
   );

   assign csr_req   = tl_cpu2csr.a_valid && !csr_valid_q;
   assign csr_hit   = tl_cpu2csr.a_address[31:5] == CSR_BASE[31:5];
   assign csr_idx   = tl_cpu2csr.a_address[4:2];
   assign csr_get   = tl_cpu2csr.a_opcode == OP_GET;
   assign csr_put   = is_write_op(tl_cpu2csr.a_opcode);
   assign csr_we    = csr_req && csr_hit && csr_put;
   assign go_idle   = csr_we && (csr_idx == CSR_IDX_DENY_OP);
   assign csr_wmask = (tl_cpu2csr.a_opcode == OP_PUT_FULL) ? 4'hF : tl_cpu2csr.a_mask;

   always_comb begin
      csr_rdata = '0;
      case (csr_idx)
         CSR_IDX_CFG:       csr_rdata = cfg_q;
         3'd1:              csr_rdata = pmpaddr_q[0];
         3'd2:              csr_rdata = pmpaddr_q[1];
         3'd3:              csr_rdata = pmpaddr_q[2];
         3'd4:              csr_rdata = pmpaddr_q[3];
         CSR_IDX_DENY_ADDR: csr_rdata = deny_addr_q;
         CSR_IDX_DENY_OP:   csr_rdata = {29'd0, deny_op_q};
         default:           csr_rdata = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (tl_h2pmp.a_valid) state_d = ST_CHECK;
         ST_CHECK:    state_d = allow ? ST_FWD : ST_DENY_RSP;
         ST_FWD:      if (tl_d2pmp.a_ready) state_d = ST_IDLE;
         ST_DENY_RSP: if (tl_h2pmp.d_ready) state_d = ST_HALT;
         ST_HALT:     if (go_idle) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         cfg_q       <= '0;
         pmpaddr_q   <= '0;
         deny_addr_q <= '0;
         deny_op_q   <= '0;
         irq_q       <= 1'b0;
         csr_valid_q <= 1'b0;
         csr_err_q   <= 1'b0;
         csr_op_q    <= '0;
         csr_size_q  <= '0;
         csr_src_q   <= '0;
         csr_data_q  <= '0;
      end else begin
         state_q <= state_d;
         irq_q   <= (state_d == ST_HALT);
         if (state_q == ST_IDLE && tl_h2pmp.a_valid) req_q <= tl_h2pmp;
         if (state_q == ST_CHECK && !allow) begin
            deny_addr_q <= req_q.a_address;
            deny_op_q   <= req_q.a_opcode;
         end

         // locked regions ignore both their cfg byte and their address word
         if (csr_we) begin
            for (int j = 0; j < PMP_REGIONS; j++) begin
               for (int b = 0; b < 4; b++) begin
                  if (csr_wmask[b] && !cfg_q[8*j+CFG_L]) begin
                     if (csr_idx == CSR_IDX_CFG && b == j)
                        cfg_q[8*j +: 8] <= tl_cpu2csr.a_data[8*b +: 8];
                     if (csr_idx == CSR_IDX_ADDR0 + 3'(j))
                        pmpaddr_q[j][8*b +: 8] <= tl_cpu2csr.a_data[8*b +: 8];
                  end
               end
            end
         end

         if (csr_req) begin
            csr_valid_q <= 1'b1;
            csr_err_q   <= !csr_hit || !(csr_get || csr_put);
            csr_op_q    <= csr_get ? OP_ACK_DATA : OP_ACK;
            csr_size_q  <= tl_cpu2csr.a_size;
            csr_src_q   <= tl_cpu2csr.a_source;
            csr_data_q  <= (csr_hit && csr_get) ? csr_rdata : 32'd0;
         end else if (csr_valid_q && tl_cpu2csr.d_ready) begin
            csr_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      tl_pmp2d         = req_q;
      tl_pmp2d.a_valid = (state_q == ST_FWD);
      tl_pmp2d.d_ready = tl_h2pmp.d_ready && (state_q != ST_DENY_RSP);

      tl_pmp2h         = tl_d2pmp;
      tl_pmp2h.a_ready = (state_q == ST_IDLE);
      if (state_q == ST_DENY_RSP) begin
         tl_pmp2h.d_valid  = 1'b1;
         tl_pmp2h.d_opcode = (req_q.a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
         tl_pmp2h.d_param  = '0;
         tl_pmp2h.d_size   = req_q.a_size;
         tl_pmp2h.d_source = req_q.a_source;
         tl_pmp2h.d_sink   = 1'b0;
         tl_pmp2h.d_data   = '0;
         tl_pmp2h.d_error  = 1'b1;
      end

      tl_csr2cpu          = '0;
      tl_csr2cpu.d_valid  = csr_valid_q;
      tl_csr2cpu.d_opcode = csr_op_q;
      tl_csr2cpu.d_size   = csr_size_q;
      tl_csr2cpu.d_source = csr_src_q;
      tl_csr2cpu.d_data   = csr_data_q;
      tl_csr2cpu.d_error  = csr_err_q;
      tl_csr2cpu.a_ready  = !csr_valid_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_wrapper_ibex_pmp_fsm.sv
// tb_wrapper_ibex_pmp_fsm: directed self-checking bench for the PMP wrapper. Rev 1.0
`default_nettype none

module tb_wrapper_ibex_pmp_fsm;
   import pmp_wrap_pkg::*;

   localparam logic [31:0] CB = 32'hFFFF_FF00;

   logic    clk = 1'b0;
   logic    rst;
   logic    irq;
   tl_h2d_t h2pmp, pmp2d, cpu;
   tl_d2h_t pmp2h, d2pmp, csr2cpu;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] r_data;
   logic        r_err;
   logic [2:0]  r_op;

   always #5 clk = ~clk;

   wrapper_ibex_pmp_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .irq_q      (irq),
      .tl_h2pmp   (h2pmp),
      .tl_pmp2h   (pmp2h),
      .tl_pmp2d   (pmp2d),
      .tl_d2pmp   (d2pmp),
      .tl_cpu2csr (cpu),
      .tl_csr2cpu (csr2cpu)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr(input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask);
      int n;
      cpu.a_valid = 1'b1; cpu.a_opcode = op; cpu.a_address = addr;
      cpu.a_data = data; cpu.a_mask = mask; cpu.a_source = 8'h3; cpu.a_size = 2'd2;
      n = 0;
      while (!csr2cpu.a_ready && n < 10) begin step(); n++; end
      step();
      cpu.a_valid = 1'b0;
      n = 0;
      while (!csr2cpu.d_valid && n < 10) begin step(); n++; end
      chk("csr_d_valid", 32'(csr2cpu.d_valid), 32'd1);
      chk("csr_d_source", 32'(csr2cpu.d_source), 32'h3);
      r_data = csr2cpu.d_data; r_err = csr2cpu.d_error; r_op = csr2cpu.d_opcode;
      step();
   endtask

   // Issue one host beat; returns with the FSM one cycle past CHECK
   task automatic host(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [7:0] src);
      h2pmp.a_valid = 1'b1; h2pmp.a_opcode = op; h2pmp.a_address = addr;
      h2pmp.a_data = data; h2pmp.a_source = src; h2pmp.a_size = 2'd2; h2pmp.a_mask = 4'hF;
      #1;
      chk("host_a_ready_idle", 32'(pmp2h.a_ready), 32'd1);
      step();
      h2pmp.a_valid = 1'b0;
      step();
   endtask

   task automatic expect_fwd(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [7:0] src);
      chk("fwd_a_valid", 32'(pmp2d.a_valid), 32'd1);
      chk("fwd_addr", pmp2d.a_address, addr);
      chk("fwd_opcode", 32'(pmp2d.a_opcode), 32'(op));
      chk("fwd_data", pmp2d.a_data, data);
      chk("fwd_source", 32'(pmp2d.a_source), 32'(src));
      chk("fwd_host_a_ready", 32'(pmp2h.a_ready), 32'd0);
      chk("fwd_irq", 32'(irq), 32'd0);
      step();
      chk("fwd_held", 32'(pmp2d.a_valid), 32'd1);
      d2pmp.a_ready = 1'b1;
      step();
      d2pmp.a_ready = 1'b0;
      chk("fwd_done_a_valid", 32'(pmp2d.a_valid), 32'd0);
      chk("fwd_done_a_ready", 32'(pmp2h.a_ready), 32'd1);
   endtask

   task automatic expect_deny(input logic [2:0] rsp_op, input logic [7:0] src);
      chk("deny_d_valid", 32'(pmp2h.d_valid), 32'd1);
      chk("deny_d_error", 32'(pmp2h.d_error), 32'd1);
      chk("deny_d_opcode", 32'(pmp2h.d_opcode), 32'(rsp_op));
      chk("deny_d_source", 32'(pmp2h.d_source), 32'(src));
      chk("deny_not_fwd", 32'(pmp2d.a_valid), 32'd0);
      h2pmp.d_ready = 1'b1;
      #1;
      chk("deny_dev_d_ready", 32'(pmp2d.d_ready), 32'd0);
      step();
      h2pmp.d_ready = 1'b0;
      chk("halt_irq", 32'(irq), 32'd1);
      chk("halt_a_ready", 32'(pmp2h.a_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      h2pmp = '0; d2pmp = '0; cpu = '0;
      cpu.d_ready = 1'b1;
      repeat (3) step();
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_fwd_valid", 32'(pmp2d.a_valid), 32'd0);
      chk("rst_host_d_valid", 32'(pmp2h.d_valid), 32'd0);
      chk("rst_csr_d_valid", 32'(csr2cpu.d_valid), 32'd0);
      rst = 1'b0;
      step();

      csr(OP_PUT_FULL, CB + 32'h00, 32'h2B2A2928, 4'h0);
      chk("cfg_wr_op", 32'(r_op), 32'(OP_ACK));
      chk("cfg_wr_err", 32'(r_err), 32'd0);
      csr(OP_PUT_FULL, CB + 32'h04, 32'h40, 4'hF);
      csr(OP_PUT_FULL, CB + 32'h08, 32'h80, 4'hF);
      csr(OP_PUT_FULL, CB + 32'h0C, 32'hC0, 4'hF);
      csr(OP_PUT_FULL, CB + 32'h10, 32'h100, 4'hF);
      chk("addr3_wr_op", 32'(r_op), 32'(OP_ACK));
      csr(OP_GET, CB + 32'h0C, 32'h0, 4'hF);
      chk("rd_addr2_op", 32'(r_op), 32'(OP_ACK_DATA));
      chk("rd_addr2", r_data, 32'hC0);
      csr(OP_GET, CB + 32'h19, 32'h0, 4'hF);
      chk("rd_denyop_init", r_data, 32'h0);

      // device response passes straight through while idle
      d2pmp.d_valid = 1'b1; d2pmp.d_data = 32'h1234ABCD; d2pmp.d_source = 8'h7;
      h2pmp.d_ready = 1'b1;
      #1;
      chk("pass_d_valid", 32'(pmp2h.d_valid), 32'd1);
      chk("pass_d_data", pmp2h.d_data, 32'h1234ABCD);
      chk("pass_d_ready", 32'(pmp2d.d_ready), 32'd1);
      d2pmp = '0; h2pmp.d_ready = 1'b0;
      step();

      host(OP_GET, 32'h5F, 32'h0, 8'h5);
      expect_fwd(OP_GET, 32'h5F, 32'h0, 8'h5);
      host(OP_PUT_FULL, 32'h9B, 32'hDEADBEEF, 8'h1);
      expect_fwd(OP_PUT_FULL, 32'h9B, 32'hDEADBEEF, 8'h1);

      host(OP_GET, 32'h28, 32'h0, 8'h2);
      expect_deny(OP_ACK_DATA, 8'h2);
      csr(OP_GET, CB + 32'h14, 32'h0, 4'hF);
      chk("rd_deny_addr", r_data, 32'h28);
      csr(OP_GET, CB + 32'h18, 32'h0, 4'hF);
      chk("rd_deny_op", r_data, 32'h4);

      h2pmp.a_valid = 1'b1; h2pmp.a_address = 32'h60; h2pmp.a_opcode = OP_GET;
      #1;
      chk("halt_host_blocked", 32'(pmp2h.a_ready), 32'd0);
      step();
      h2pmp.a_valid = 1'b0;
      chk("halt_irq_held", 32'(irq), 32'd1);
      csr(OP_PUT_PARTIAL, CB + 32'h1A, 32'h0, 4'b0100);
      chk("goidle_op", 32'(r_op), 32'(OP_ACK));
      chk("goidle_irq", 32'(irq), 32'd0);
      chk("goidle_a_ready", 32'(pmp2h.a_ready), 32'd1);

      // TOR lower bound inclusive, write to read-only region, upper bound exclusive
      host(OP_GET, 32'h40, 32'h0, 8'h4);
      expect_fwd(OP_GET, 32'h40, 32'h0, 8'h4);
      host(OP_PUT_FULL, 32'h44, 32'h5, 8'h6);
      expect_deny(OP_ACK, 8'h6);
      csr(OP_GET, CB + 32'h18, 32'h0, 4'hF);
      chk("rd_deny_op_put", r_data, 32'h0);
      csr(OP_PUT_FULL, CB + 32'h18, 32'h0, 4'hF);
      host(OP_GET, 32'h100, 32'h0, 8'h9);
      expect_deny(OP_ACK_DATA, 8'h9);
      csr(OP_PUT_FULL, CB + 32'h18, 32'h0, 4'hF);
      chk("idle_again", 32'(pmp2h.a_ready), 32'd1);

      csr(OP_PUT_FULL, CB + 32'h00, 32'h2B2AA928, 4'hF);
      csr(OP_PUT_FULL, CB + 32'h08, 32'h10, 4'hF);
      chk("locked_wr_ack", 32'(r_op), 32'(OP_ACK));
      csr(OP_GET, CB + 32'h08, 32'h0, 4'hF);
      chk("locked_addr1", r_data, 32'h80);
      csr(OP_PUT_FULL, CB + 32'h00, 32'h2B2A0028, 4'hF);
      csr(OP_GET, CB + 32'h00, 32'h0, 4'hF);
      chk("locked_cfg", r_data, 32'h2B2AA928);
      csr(OP_GET, 32'hFFFF_0000, 32'h0, 4'hF);
      chk("csr_miss_err", 32'(r_err), 32'd1);

      host(OP_GET, 32'h5F, 32'h0, 8'h1);
      chk("pre_rst_fwd", 32'(pmp2d.a_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_fwd", 32'(pmp2d.a_valid), 32'd0);
      chk("async_rst_ready", 32'(pmp2h.a_ready), 32'd1);
      step();
      rst = 1'b0;
      step();
      csr(OP_GET, CB + 32'h00, 32'h0, 4'hF);
      chk("rst_cfg_cleared", r_data, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
